// File: rtl/gfx256_pixel_wr_ctrl.sv
// gfx256_pixel_wr_ctrl: merges pixel writes into one 256-bit line
// buffer and writes the line back with byte enables.
module gfx256_pixel_wr_ctrl #(
  parameter int AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          pix_req_i,
  output logic          pix_ack_o,
  input  logic [AW-1:0] pix_addr_i,
  input  logic [31:0]   pix_color_i,
  input  logic [1:0]    color_depth_i,
  input  logic          flush_i,
  output logic          flush_done_o,
  output logic          mem_cyc_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_adr_o,
  output logic [31:0]   mem_sel_o,
  output logic [255:0]  mem_dat_o,
  input  logic          mem_ack_i,
  output logic          busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    WB   = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [AW-6:0] line_adr;
  logic [255:0]  buf_q;
  logic [31:0]   sel_acc;
  logic [31:0]   sel_d;
  logic          flush_pend;

  logic          empty;
  logic          same_line;
  logic          accept;
  logic          in_wb;
  logic [4:0]    off;
  logic [5:0]    nbytes;
  logic [5:0]    rel;
  logic [31:0]   shifted;
  logic [31:0]   wr_mask;
  logic [255:0]  wr_buf;

  assign empty     = (sel_acc == 32'h0);
  assign same_line = (pix_addr_i[AW-1:5] == line_adr);
  assign in_wb     = (state_q == WB);
  assign off       = pix_addr_i[4:0];
  assign nbytes    = {4'b0, color_depth_i} + 6'd1;

  // Flush wins over a pixel arriving in the same cycle.
  assign accept = rst_ni && !in_wb && pix_req_i
               && !flush_pend && !flush_i
               && (empty || same_line);

  assign pix_ack_o    = accept;
  assign flush_done_o = flush_pend && !in_wb && empty;
  assign busy_o       = in_wb || !empty;

  assign mem_cyc_o = in_wb;
  assign mem_we_o  = in_wb;
  assign mem_adr_o = in_wb ? {line_adr, 5'b0} : '0;
  assign mem_sel_o = in_wb ? sel_acc : '0;
  assign mem_dat_o = in_wb ? buf_q : '0;

  // Byte lanes hit by the pixel; lanes past byte 31 fall off.
  always_comb begin
    wr_mask = '0;
    wr_buf  = buf_q;
    rel     = '0;
    shifted = '0;
    for (int i = 0; i < 32; i++) begin
      rel     = 6'(i) - {1'b0, off};
      shifted = pix_color_i >> {rel[1:0], 3'b000};
      if (rel < nbytes) begin
        wr_mask[i]        = 1'b1;
        wr_buf[8*i +: 8]  = shifted[7:0];
      end
    end
  end

  // Next state and next byte-enable accumulator.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_acc;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d = sel_acc | wr_mask;
          if (&sel_d) state_d = WB;
        end else if (flush_pend && !empty) begin
          state_d = WB;
        end else if (pix_req_i && !empty && !same_line) begin
          state_d = WB;
        end
      end
      WB: begin
        if (mem_ack_i) begin
          sel_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sel_acc    <= '0;
      flush_pend <= 1'b0;
      line_adr   <= '0;
    end else begin
      state_q    <= state_d;
      sel_acc    <= sel_d;
      flush_pend <= flush_i || (flush_pend && !flush_done_o);
      if (accept) line_adr <= pix_addr_i[AW-1:5];
    end
  end

  // Line data; stale bytes are masked by sel_acc so no reset needed.
  always_ff @(posedge clk_i) begin
    if (accept) buf_q <= wr_buf;
  end

endmodule

// File: tb/tb_gfx256_pixel_wr_ctrl.sv
// tb_gfx256_pixel_wr_ctrl: directed checks of pixel merging,
// line writeback, flush handling and reset behaviour.
module tb_gfx256_pixel_wr_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         pix_req_i;
  logic         pix_ack_o;
  logic [31:0]  pix_addr_i;
  logic [31:0]  pix_color_i;
  logic [1:0]   color_depth_i;
  logic         flush_i;
  logic         flush_done_o;
  logic         mem_cyc_o;
  logic         mem_we_o;
  logic [31:0]  mem_adr_o;
  logic [31:0]  mem_sel_o;
  logic [255:0] mem_dat_o;
  logic         mem_ack_i;
  logic         busy_o;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  gfx256_pixel_wr_ctrl #(.AW(32)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pix_req_i    (pix_req_i),
    .pix_ack_o    (pix_ack_o),
    .pix_addr_i   (pix_addr_i),
    .pix_color_i  (pix_color_i),
    .color_depth_i(color_depth_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .mem_cyc_o    (mem_cyc_o),
    .mem_we_o     (mem_we_o),
    .mem_adr_o    (mem_adr_o),
    .mem_sel_o    (mem_sel_o),
    .mem_dat_o    (mem_dat_o),
    .mem_ack_i    (mem_ack_i),
    .busy_o       (busy_o)
  );

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] c,
                    input logic [1:0] d);
    int n;
    n = 0;
    @(negedge clk_i);
    pix_req_i     = 1'b1;
    pix_addr_i    = a;
    pix_color_i   = c;
    color_depth_i = d;
    #1;
    while (!pix_ack_o && n < 20) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk("wr_ack", pix_ack_o, 1);
    @(posedge clk_i);
    #1;
    pix_req_i = 1'b0;
  endtask

  task automatic wait_wb(input logic [31:0] adr,
                         input logic [31:0] sel);
    int n;
    n = 0;
    while (!mem_cyc_o && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("wb_cyc", mem_cyc_o, 1);
    chk("wb_we", mem_we_o, 1);
    chk("wb_adr", mem_adr_o, adr);
    chk("wb_sel", mem_sel_o, sel);
  endtask

  task automatic flush_wb(input logic [31:0] adr,
                          input logic [31:0] sel);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    wait_wb(adr, sel);
  endtask

  task automatic ack_wb(input logic done);
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    mem_ack_i = 1'b0;
    chk("ack_cyc", mem_cyc_o, 0);
    chk("ack_done", flush_done_o, done);
  endtask

  initial begin
    rst_ni        = 1'b0;
    pix_req_i     = 1'b1;
    pix_addr_i    = 32'h100;
    pix_color_i   = 32'h0;
    color_depth_i = 2'd0;
    flush_i       = 1'b0;
    mem_ack_i     = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ack", pix_ack_o, 0);
    chk("rst_cyc", mem_cyc_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", flush_done_o, 0);
    chk("rst_sel", mem_sel_o, 0);
    pix_req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // two 8bpp bytes then flush
    wr(32'h100, 32'hA1, 2'd0);
    wr(32'h101, 32'hB2, 2'd0);
    chk("m_busy", busy_o, 1);
    flush_wb(32'h100, 32'h3);
    chk("m_dat", mem_dat_o[15:0], 16'hB2A1);
    ack_wb(1'b1);
    @(posedge clk_i);
    #1;
    chk("m_done_clr", flush_done_o, 0);
    chk("m_idle", busy_o, 0);

    // different line forces writeback
    wr(32'h104, 32'hDDCCBBAA, 2'd3);
    @(negedge clk_i);
    pix_req_i   = 1'b1;
    pix_addr_i  = 32'h120;
    pix_color_i = 32'h55;
    color_depth_i = 2'd0;
    #1;
    chk("d_noack", pix_ack_o, 0);
    @(posedge clk_i);
    #1;
    wait_wb(32'h100, 32'hF0);
    chk("d_dat", mem_dat_o[63:32], 32'hDDCCBBAA);
    chk("d_wbnoack", pix_ack_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("d_hold", mem_sel_o, 32'hF0);
    ack_wb(1'b0);
    chk("d_ack2", pix_ack_o, 1);
    @(posedge clk_i);
    #1;
    pix_req_i = 1'b0;
    chk("d_busy", busy_o, 1);
    flush_wb(32'h120, 32'h1);
    chk("d_dat2", mem_dat_o[7:0], 8'h55);
    ack_wb(1'b1);

    // full line auto writeback
    for (int i = 0; i < 8; i++)
      wr(32'h200 + 32'(4 * i), 32'h11111111 * (i + 1), 2'd3);
    chk("f_cyc", mem_cyc_o, 1);
    wait_wb(32'h200, 32'hFFFFFFFF);
    chk("f_lo", mem_dat_o[31:0], 32'h11111111);
    chk("f_hi", mem_dat_o[255:224], 32'h88888888);
    ack_wb(1'b0);
    chk("f_idle", busy_o, 0);

    // 24bpp straddling line end
    wr(32'h11E, 32'h332211, 2'd2);
    flush_wb(32'h100, 32'hC0000000);
    chk("s_hi", mem_dat_o[255:240], 16'h2211);
    chk("s_nowrap", mem_dat_o[7:0], 8'h11);
    ack_wb(1'b1);

    // last write wins
    wr(32'h140, 32'hAA, 2'd0);
    wr(32'h140, 32'hBB, 2'd0);
    flush_wb(32'h140, 32'h1);
    chk("l_dat", mem_dat_o[7:0], 8'hBB);
    ack_wb(1'b1);

    // flush on empty line
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    chk("e_done", flush_done_o, 1);
    chk("e_cyc", mem_cyc_o, 0);
    @(posedge clk_i);
    #1;
    chk("e_clr", flush_done_o, 0);

    // flush and pixel together
    @(negedge clk_i);
    flush_i     = 1'b1;
    pix_req_i   = 1'b1;
    pix_addr_i  = 32'h300;
    pix_color_i = 32'h77;
    color_depth_i = 2'd0;
    #1;
    chk("p_ack0", pix_ack_o, 0);
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    chk("p_done", flush_done_o, 1);
    chk("p_ack1", pix_ack_o, 0);
    @(posedge clk_i);
    #1;
    chk("p_ack2", pix_ack_o, 1);
    chk("p_done2", flush_done_o, 0);
    @(posedge clk_i);
    #1;
    pix_req_i = 1'b0;
    flush_wb(32'h300, 32'h1);
    chk("p_dat", mem_dat_o[7:0], 8'h77);
    ack_wb(1'b1);

    // reset in the middle of writeback
    wr(32'h400, 32'h99, 2'd0);
    flush_wb(32'h400, 32'h1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("r_cyc", mem_cyc_o, 0);
    chk("r_busy", busy_o, 0);
    chk("r_sel", mem_sel_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    mem_ack_i = 1'b0;
    chk("r_late_cyc", mem_cyc_o, 0);
    chk("r_late_busy", busy_o, 0);
    chk("r_late_done", flush_done_o, 0);
    @(posedge clk_i);
    #1;
    chk("r_quiet", mem_cyc_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gfx256_pixel_wr_ctrl.md
GFX256_PIXEL_WR_CTRL -- requirements
Module: gfx256_pixel_wr_ctrl

Interface
REQ-001 Parameter AW, default 32, SHALL set the byte-address width of pix_addr_i and mem_adr_o.
REQ-002 clk_i  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-003 rst_ni  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 pix_req_i  in  1  SHALL signal a pixel write request.
REQ-005 pix_ack_o  out  1  SHALL signal that the request is accepted this cycle.
REQ-006 pix_addr_i  in  AW  SHALL carry the pixel byte address.
REQ-007 pix_color_i  in  32  SHALL carry the pixel colour, right-aligned.
REQ-008 color_depth_i  in  2  SHALL give bytes per pixel minus 1 (0=8bpp, 1=16bpp, 2=24bpp, 3=32bpp).
REQ-009 flush_i  in  1  SHALL be a one-cycle flush request pulse.
REQ-010 flush_done_o  out  1  SHALL pulse for one cycle when a flush completes.
REQ-011 mem_cyc_o / mem_we_o  out  1 / 1  SHALL mark a memory write cycle.
REQ-012 mem_adr_o  out  AW  SHALL carry the 32-byte-aligned line address, with bits [4:0]=0.
REQ-013 mem_sel_o  out  32  SHALL carry the byte enables; bit n enables byte n.
REQ-014 mem_dat_o  out  256  SHALL carry the line write data.
REQ-015 mem_ack_i  in  1  SHALL acknowledge the memory cycle.
REQ-016 busy_o  out  1  SHALL be high when the state is not IDLE or any byte is buffered.

Function
REQ-017 Block SHALL hold one 256-bit line buffer, tag line_adr = addr[AW-1:5], and a 32-bit accumulated byte-enable sel_acc; the line is empty when sel_acc==0.
REQ-018 States SHALL be IDLE and WB; reset state SHALL be IDLE.
REQ-019 In IDLE, pix_ack_o SHALL equal pix_req_i & !flush_pend & (empty | addr[AW-1:5]==line_adr) as a combinational output with zero-cycle latency.
REQ-020 On accept, the block SHALL apply the following updates:
 - load line_adr (load if empty);
 - byte offset o=addr[4:0], n=depth+1;
 - merge bytes o..o+n-1 of the buffer with pix_color_i bytes 0..n-1;
 - OR the matching bits into sel_acc;
 - leave all other buffer bytes unchanged.
REQ-021 A pixel straddling the line end (o+n>32) SHALL have its bytes past byte 31 dropped, with no wrap into byte 0.
REQ-022 Same-byte rewrites SHALL use last-write-wins.
REQ-023 IDLE->WB SHALL occur on any one of these conditions:
 - a request to a different line while not empty (that request SHALL stay un-acked);
 - sel_acc becoming 32'hFFFFFFFF after an accept (full-line auto-writeback);
 - flush_pend with sel_acc nonzero.
REQ-024 In WB the outputs SHALL be mem_cyc_o=mem_we_o=1, mem_adr_o={line_adr,5'b0}, mem_sel_o=sel_acc, mem_dat_o=buffer, all held stable until mem_ack_i.
REQ-025 In WB, pix_ack_o SHALL be 0.
REQ-026 On mem_ack_i in WB, the block SHALL do the following:
 - clear sel_acc;
 - return to IDLE and deassert mem_cyc_o next cycle;
 - leave the buffer data unchanged, since sel masks it.
REQ-027 mem_ack_i outside WB SHALL be ignored.
REQ-028 flush_i SHALL set flush_pend in any state.
REQ-029 flush_pend SHALL complete with flush_done_o=1 in these cases:
 - if empty in IDLE, on the following cycle;
 - otherwise, in the cycle after the WB ack;
 - it SHALL then be cleared.
REQ-030 flush_i arriving during WB SHALL be served after that WB completes, via a new WB only if sel_acc is nonzero.
REQ-031 flush_i together with pix_req_i SHALL give flush priority; the pixel SHALL be held un-acked until flush_done_o.
REQ-032 An auto-writeback cycle SHALL not accept a new pixel in the same cycle in which it enters WB.

Reset
REQ-033 While rst_ni=0, the block SHALL hold:
 - state IDLE and sel_acc=0;
 - flush_pend=0;
 - all outputs 0 (pix_ack_o, flush_done_o, mem_cyc_o, mem_we_o, mem_sel_o, mem_adr_o, mem_dat_o, busy_o).
REQ-034 Reset asserted mid-WB SHALL drop mem_cyc_o immediately and discard the buffered bytes; a late mem_ack_i SHALL be ignored.

Verification
REQ-035 8bpp writes of 0xA1 and 0xB2 to 0x100 and 0x101, then flush -> one WB with adr 0x100, sel 0x00000003, dat[15:0]=0xB2A1, then flush_done_o.
REQ-036 32bpp write to 0x104 followed by 8bpp write to 0x120 -> second request un-acked; WB adr 0x100, sel 0x000000F0; after ack, 0x120 accepted.
REQ-037 Eight 32bpp writes covering 0x200..0x21F -> auto WB with sel 0xFFFFFFFF without a flush.
REQ-038 24bpp write to 0x11E with colour 0x332211 -> sel 0xC0000000, bytes 30..31 = 0x11, 0x22; byte 0x33 dropped.
REQ-039 flush_i on an empty line -> flush_done_o the next cycle, no mem_cyc_o; flush_i and pix_req_i in the same cycle -> flush_done_o before pix_ack_o.
REQ-040 rst_ni low during WB with mem_ack_i withheld -> mem_cyc_o 0 and busy_o 0; a later mem_ack_i produces no activity.
